alu_writeback: RTL and testbench

//  Execute->writeback stage directly downstream of the 16-bit ALU. Registers the ALU's 32-bit

---
 rtl/alu_writeback.sv | 134 +++++++++++++
 tb/tb_alu_writeback.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Execute->writeback stage: registers ALU results and drives the register-file write port.
// MUL results retire as two writes (low half to rd, high half to rd+1).
module alu_writeback #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_result,
  input  logic                in_zero,
  input  logic [3:0]          in_alu_op,
  input  logic [ADDR_W-1:0]   in_rd,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                z_flag,
  output logic                c_flag,
  output logic [15:0]         retire_cnt
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t            state_reg, state_next;
  logic              mul_reg, mul_next;
  logic [ADDR_W-1:0] rd_reg, rd_next;
  logic [DATA_W-1:0] hi_reg, hi_next;
  logic              rf_we_reg, rf_we_next;
  logic [ADDR_W-1:0] rf_waddr_reg, rf_waddr_next;
  logic [DATA_W-1:0] rf_wdata_reg, rf_wdata_next;
  logic              z_flag_reg, z_flag_next;
  logic              c_flag_reg, c_flag_next;
  logic [15:0]       retire_cnt_reg, retire_cnt_next;

  logic              accept;
  logic              op_mul, op_write, op_carry;
  logic [ADDR_W-1:0] rd_inc;

  // Address 0 may be hard-wired; its writes are dropped but everything else proceeds.
  function automatic logic write_allowed(input logic [ADDR_W-1:0] addr);
    return !(ZERO_REG_RO && (addr == '0));
  endfunction

  assign op_mul   = (in_alu_op == 4'b1001);
  assign op_write = ((in_alu_op >= 4'b0001) && (in_alu_op <= 4'b1000)) || (in_alu_op == 4'b1010);
  assign op_carry = (in_alu_op == 4'b0001) || (in_alu_op == 4'b0010);
  assign rd_inc   = rd_reg + 1'b1;

  // The only stall: second (high-half) cycle of a MUL.
  assign in_ready = !rst && !((state_reg == LO) && mul_reg);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next      = state_reg;
    mul_next        = mul_reg;
    rd_next         = rd_reg;
    hi_next         = hi_reg;
    rf_we_next      = 1'b0;
    rf_waddr_next   = rf_waddr_reg;
    rf_wdata_next   = rf_wdata_reg;
    z_flag_next     = z_flag_reg;
    c_flag_next     = c_flag_reg;
    retire_cnt_next = retire_cnt_reg;

    if ((state_reg == LO) && mul_reg) begin
      state_next      = HI;
      mul_next        = 1'b0;
      rf_we_next      = write_allowed(rd_inc);
      rf_waddr_next   = rd_inc;
      rf_wdata_next   = hi_reg;
      retire_cnt_next = retire_cnt_reg + 16'd1;
    end else begin
      state_next = IDLE;
      mul_next   = 1'b0;
      if (accept) begin
        if (op_write || op_mul) begin
          state_next    = LO;
          mul_next      = op_mul;
          rd_next       = in_rd;
          hi_next       = in_result[2*DATA_W-1:DATA_W];
          rf_we_next    = write_allowed(in_rd);
          rf_waddr_next = in_rd;
          rf_wdata_next = in_result[DATA_W-1:0];
          z_flag_next   = in_zero;
          if (op_carry) begin
            c_flag_next = in_result[DATA_W];
          end
          // A MUL is counted when its high half retires.
          if (!op_mul) begin
            retire_cnt_next = retire_cnt_reg + 16'd1;
          end
        end else begin
          retire_cnt_next = retire_cnt_reg + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mul_reg        <= 1'b0;
      rd_reg         <= '0;
      hi_reg         <= '0;
      rf_we_reg      <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
      z_flag_reg     <= 1'b0;
      c_flag_reg     <= 1'b0;
      retire_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      mul_reg        <= mul_next;
      rd_reg         <= rd_next;
      hi_reg         <= hi_next;
      rf_we_reg      <= rf_we_next;
      rf_waddr_reg   <= rf_waddr_next;
      rf_wdata_reg   <= rf_wdata_next;
      z_flag_reg     <= z_flag_next;
      c_flag_reg     <= c_flag_next;
      retire_cnt_reg <= retire_cnt_next;
    end
  end

  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;
  assign z_flag     = z_flag_reg;
  assign c_flag     = c_flag_reg;
  assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: hand-computed expectations checked with immediate assertions.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic [3:0]  in_alu_op;
  logic [3:0]  in_rd;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        z_flag;
  logic        c_flag;
  logic [15:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(16), .ADDR_W(4), .ZERO_REG_RO(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_zero    (in_zero),
    .in_alu_op  (in_alu_op),
    .in_rd      (in_rd),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .z_flag     (z_flag),
    .c_flag     (c_flag),
    .retire_cnt (retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res,
                       input logic z, input logic [3:0] rd);
    in_valid  = v;
    in_alu_op = op;
    in_result = res;
    in_zero   = z;
    in_rd     = rd;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [3:0] wa,
                            input logic [15:0] wd);
    check({tag, ".rf_we"}, rf_we, we);
    check({tag, ".rf_waddr"}, rf_waddr, wa);
    check({tag, ".rf_wdata"}, rf_wdata, wd);
  endtask

  task automatic check_state(input string tag, input logic z, input logic c,
                             input logic [15:0] cnt);
    check({tag, ".z_flag"}, z_flag, z);
    check({tag, ".c_flag"}, c_flag, c);
    check({tag, ".retire_cnt"}, retire_cnt, cnt);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    tick();
    tick();
    $display("reset applied");
    check_port("reset", 1'b0, 4'h0, 16'h0000);
    check_state("reset", 1'b0, 1'b0, 16'h0000);
    check("reset.in_ready", in_ready, 1'b0);

    // A transfer presented during reset must be dropped.
    drive(1'b1, 4'h1, 32'h0001_0003, 1'b0, 4'h2);
    tick();
    $display("ADD presented during reset");
    check_port("rst_drop", 1'b0, 4'h0, 16'h0000);
    check_state("rst_drop", 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    #1;
    check("idle.in_ready", in_ready, 1'b1);

    // ADD with carry out.
    drive(1'b1, 4'h1, 32'h0001_0003, 1'b0, 4'h2);
    tick();
    $display("ADD res=0x00010003 rd=2");
    check_port("add", 1'b1, 4'h2, 16'h0003);
    check_state("add", 1'b0, 1'b1, 16'd1);
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    tick();
    check("add_idle.rf_we", rf_we, 1'b0);

    // MUL to r15: high half wraps to r0 and is suppressed.
    drive(1'b1, 4'h9, 32'h1234_5678, 1'b0, 4'hF);
    tick();
    $display("MUL res=0x12345678 rd=15 low half");
    check_port("mul15_lo", 1'b1, 4'hF, 16'h5678);
    check("mul15_lo.in_ready", in_ready, 1'b0);
    check_state("mul15_lo", 1'b0, 1'b1, 16'd1);
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    tick();
    $display("MUL rd=15 high half");
    check_port("mul15_hi", 1'b0, 4'h0, 16'h1234);
    check_state("mul15_hi", 1'b0, 1'b1, 16'd2);
    check("mul15_hi.in_ready", in_ready, 1'b1);

    // MUL to r6 with the following AND held valid through the stall.
    drive(1'b1, 4'h9, 32'hABCD_0001, 1'b0, 4'h6);
    tick();
    $display("MUL res=0xABCD0001 rd=6 low half");
    check_port("mul6_lo", 1'b1, 4'h6, 16'h0001);
    check("mul6_lo.in_ready", in_ready, 1'b0);
    drive(1'b1, 4'h3, 32'h0000_00F0, 1'b0, 4'h3);
    tick();
    $display("MUL rd=6 high half, AND stalled");
    check_port("mul6_hi", 1'b1, 4'h7, 16'hABCD);
    check("mul6_hi.retire_cnt", retire_cnt, 16'd3);
    tick();
    $display("AND res=0x00F0 rd=3 after stall");
    check_port("and_stall", 1'b1, 4'h3, 16'h00F0);
    check_state("and_stall", 1'b0, 1'b1, 16'd4);

    // Back-to-back SUB then AND.
    drive(1'b1, 4'h2, 32'h0000_0000, 1'b1, 4'h1);
    tick();
    $display("SUB res=0 rd=1");
    check_port("sub", 1'b1, 4'h1, 16'h0000);
    check_state("sub", 1'b1, 1'b0, 16'd5);
    drive(1'b1, 4'h3, 32'h0000_00F0, 1'b0, 4'h3);
    tick();
    $display("AND res=0x00F0 rd=3");
    check_port("and", 1'b1, 4'h3, 16'h00F0);
    check_state("and", 1'b0, 1'b0, 16'd6);

    // ADD setting c=1, z=0 ahead of the NOPs.
    drive(1'b1, 4'h1, 32'h0001_0000, 1'b0, 4'h5);
    tick();
    $display("ADD res=0x00010000 rd=5");
    check_port("add5", 1'b1, 4'h5, 16'h0000);
    check_state("add5", 1'b0, 1'b1, 16'd7);
    drive(1'b1, 4'h0, 32'h0, 1'b1, 4'h8);
    tick();
    $display("NOP op=0000");
    check("nop0.rf_we", rf_we, 1'b0);
    check_state("nop0", 1'b0, 1'b1, 16'd8);
    drive(1'b1, 4'hF, 32'h0, 1'b1, 4'h9);
    tick();
    $display("NOP op=1111");
    check("nopf.rf_we", rf_we, 1'b0);
    check_state("nopf", 1'b0, 1'b1, 16'd9);

    // Write to r0 is suppressed but still retires and sets flags.
    drive(1'b1, 4'h4, 32'h0000_0000, 1'b1, 4'h0);
    tick();
    $display("OP4 res=0 rd=0");
    check("r0.rf_we", rf_we, 1'b0);
    check_state("r0", 1'b1, 1'b1, 16'd10);

    // Reset during the low-half cycle of a MUL.
    drive(1'b1, 4'h9, 32'h5555_AAAA, 1'b0, 4'h4);
    tick();
    $display("MUL res=0x5555AAAA rd=4 low half");
    check_port("mul4_lo", 1'b1, 4'h4, 16'hAAAA);
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    tick();
    $display("reset during MUL low half");
    check_port("mul4_rst", 1'b0, 4'h0, 16'h0000);
    check_state("mul4_rst", 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    tick();
    check_port("mul4_after", 1'b0, 4'h0, 16'h0000);
    check("mul4_after.retire_cnt", retire_cnt, 16'd0);

    // 0x10000 accepted NOPs wrap the counter.
    drive(1'b1, 4'h0, 32'h0, 1'b0, 4'h0);
    repeat (65535) @(posedge clk);
    #1;
    $display("65535 NOPs retired");
    check("wrap.pre", retire_cnt, 16'hFFFF);
    tick();
    $display("65536 NOPs retired");
    check("wrap.post", retire_cnt, 16'h0000);
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    tick();
    check("wrap.idle", retire_cnt, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
